// File: rtl/irq_controller.sv
// Fixed-priority, non-nesting interrupt controller for VerySimpleCPU.
// Edge-latched requests, software mask, one committed request at a time.
module irq_controller #(
  parameter int              N_SRC    = 4,
  parameter int              SIZE     = 14,
  parameter logic [SIZE-1:0] VEC_BASE = 14'h3F0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             int_ack,
  input  logic             int_done,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             interrupt,
  output logic [SIZE-1:0]  vec_addr,
  output logic [3:0]       active_id,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [N_SRC-1:0] irq_prev_reg;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic [3:0]       active_id_reg, active_id_next;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [3:0]       winner;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign rise[gi]    = irq_src[gi] & ~irq_prev_reg[gi];
      assign ack_clr[gi] = (active_id_reg == 4'(gi));
    end
  endgenerate

  assign eligible = pending_reg & mask_reg;

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    active_id_next = active_id_reg;
    pending_next   = pending_reg | rise;
    mask_next      = mask_we ? mask_din : mask_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          active_id_next = winner;
          state_next     = REQ;
        end
      end
      REQ: begin
        // A fresh edge on the acknowledged source re-pends it (set wins).
        if (int_ack) begin
          pending_next = (pending_reg & ~ack_clr) | rise;
          state_next   = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      irq_prev_reg  <= '0;
      pending_reg   <= '0;
      mask_reg      <= '0;
      active_id_reg <= '0;
    end else begin
      state_reg     <= state_next;
      irq_prev_reg  <= irq_src;
      pending_reg   <= pending_next;
      mask_reg      <= mask_next;
      active_id_reg <= active_id_next;
    end
  end

  assign mask      = mask_reg;
  assign pending   = pending_reg;
  assign active_id = active_id_reg;
  assign interrupt = (state_reg == REQ);
  assign busy      = (state_reg != IDLE);
  assign vec_addr  = interrupt ? (VEC_BASE + SIZE'(active_id_reg)) : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a cycle model checked on every edge,
// plus literal expectations at the key points of each scenario.
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_src;
  logic        mask_we;
  logic [3:0]  mask_din;
  logic        int_ack;
  logic        int_done;
  logic [3:0]  mask;
  logic [3:0]  pending;
  logic        interrupt;
  logic [13:0] vec_addr;
  logic [3:0]  active_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  irq_controller #(.N_SRC(4), .SIZE(14), .VEC_BASE(14'h3F0)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we),
    .mask_din(mask_din), .int_ack(int_ack), .int_done(int_done),
    .mask(mask), .pending(pending), .interrupt(interrupt),
    .vec_addr(vec_addr), .active_id(active_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: "phase" is where the current request stands in its life:
  // no request, waiting for the CPU to take it, or routine running.
  bit [3:0] m_mask, m_pending, m_prev;
  int       m_phase;   // 0 none, 1 waiting for ack, 2 in service
  int       m_id;

  task automatic model_step();
    bit [3:0] edges;
    bit [3:0] nxt;
    edges = irq_src & ~m_prev;
    if (rst) begin
      m_mask = 0; m_pending = 0; m_prev = 0; m_phase = 0; m_id = 0;
      return;
    end
    nxt = m_pending | edges;
    if (m_phase == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pending[i] && m_mask[i]) begin
          m_id = i; m_phase = 1; break;
        end
      end
    end else if (m_phase == 1 && int_ack) begin
      nxt[m_id] = edges[m_id];
      m_phase = 2;
    end else if (m_phase == 2 && int_done) begin
      m_phase = 0;
    end
    if (mask_we) m_mask = mask_din;
    m_prev    = irq_src;
    m_pending = nxt;
  endtask

  initial begin
    m_mask = 0; m_pending = 0; m_prev = 0; m_phase = 0; m_id = 0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("mask",      32'(mask),      32'(m_mask));
      check("pending",   32'(pending),   32'(m_pending));
      check("interrupt", 32'(interrupt), 32'(m_phase == 1));
      check("busy",      32'(busy),      32'(m_phase != 0));
      check("active_id", 32'(active_id), 32'(m_id));
      check("vec_addr",  32'(vec_addr),  (m_phase == 1) ? 32'h3F0 + 32'(m_id) : 32'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [3:0] v);
    mask_we = 1'b1; mask_din = v; tick(); mask_we = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    irq_src = v; tick(); irq_src = 4'b0000;
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1; tick(); int_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = 0; mask_we = 0; mask_din = 0; int_ack = 0; int_done = 0;
    repeat (3) tick();
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_mask",    32'(mask),    32'h0);
    check("reset_irq",     32'(interrupt), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_vec",     32'(vec_addr), 32'h0);
    rst = 1'b0;

    // Basic entry and exit on source 2
    write_mask(4'b1111);
    irq_src = 4'b0100; tick();
    check("basic_pend", 32'(pending), 32'h4);
    check("basic_noirq_yet", 32'(interrupt), 32'h0);
    irq_src = 4'b0000; tick();
    check("basic_irq", 32'(interrupt), 32'h1);
    check("basic_vec", 32'(vec_addr), 32'h3F2);
    ack();
    check("basic_ack_irq", 32'(interrupt), 32'h0);
    check("basic_ack_pend", 32'(pending), 32'h0);
    check("basic_ack_busy", 32'(busy), 32'h1);
    tick();
    done();
    check("basic_done_busy", 32'(busy), 32'h0);

    // Priority and queuing: 3 and 1 together
    pulse_src(4'b1010);
    tick();
    check("prio_id", 32'(active_id), 32'h1);
    check("prio_vec", 32'(vec_addr), 32'h3F1);
    ack();
    tick();
    done();
    check("queue_gap", 32'(interrupt), 32'h0);
    tick();
    check("queue_irq", 32'(interrupt), 32'h1);
    check("queue_id", 32'(active_id), 32'h3);
    check("queue_vec", 32'(vec_addr), 32'h3F3);
    ack();
    done();

    // Masking holds the request pending until enabled
    write_mask(4'b0000);
    pulse_src(4'b0001);
    tick();
    check("mask_pend", 32'(pending), 32'h1);
    check("mask_noirq", 32'(interrupt), 32'h0);
    write_mask(4'b0001);
    check("mask_wr_noirq", 32'(interrupt), 32'h0);
    tick();
    check("mask_irq", 32'(interrupt), 32'h1);
    check("mask_vec", 32'(vec_addr), 32'h3F0);
    ack();
    done();

    // No nesting, then masking a committed request
    write_mask(4'b1111);
    pulse_src(4'b0100);
    tick();
    ack();
    pulse_src(4'b0001);
    repeat (3) begin
      check("nest_blocked", 32'(interrupt), 32'h0);
      tick();
    end
    check("nest_pend", 32'(pending), 32'h1);
    done();
    check("nest_gap", 32'(interrupt), 32'h0);
    tick();
    check("nest_irq_id", 32'(active_id), 32'h0);
    write_mask(4'b1110);
    check("commit_irq", 32'(interrupt), 32'h1);
    ack();
    check("commit_acked", 32'(interrupt), 32'h0);
    check("commit_pend", 32'(pending), 32'h0);
    done();

    // Set wins when a new edge lands on the ack cycle
    write_mask(4'b1111);
    pulse_src(4'b0010);
    tick();
    irq_src = 4'b0010; int_ack = 1'b1; tick();
    irq_src = 4'b0000; int_ack = 1'b0;
    check("setwin_pend", 32'(pending), 32'h2);
    check("setwin_busy", 32'(busy), 32'h1);
    done();
    tick();
    check("setwin_rereq", 32'(interrupt), 32'h1);
    check("setwin_id", 32'(active_id), 32'h1);
    ack();
    done();

    // Stray strobes in IDLE are ignored
    ack();
    done();
    check("stray_busy", 32'(busy), 32'h0);
    check("stray_irq", 32'(interrupt), 32'h0);
    check("stray_id_hold", 32'(active_id), 32'h1);

    // A held level pends once only
    irq_src = 4'b0100; tick(); tick();
    ack();
    done();
    repeat (3) tick();
    check("level_once", 32'(interrupt), 32'h0);
    irq_src = 4'b0000; tick();

    // Reset in the middle of a request
    pulse_src(4'b0010);
    pulse_src(4'b1000);
    check("rstmid_pre_pend", 32'(pending), 32'hA);
    check("rstmid_pre_irq", 32'(interrupt), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstmid_irq", 32'(interrupt), 32'h0);
    check("rstmid_vec", 32'(vec_addr), 32'h0);
    check("rstmid_pend", 32'(pending), 32'h0);
    check("rstmid_mask", 32'(mask), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
